smem_responder: RTL and testbench

- Memory-side responder for the SP-core array's per-lane load/store interface.
- Accepts the broadcast MRead/MWrite strobes plus per-lane addr/data.
- Serializes enabled lanes onto one single-port synchronous RAM, returns per-lane read data on q, and signals completion on MReady.
- Sits between the SM controller/core array and the shared data memory.

---
 rtl/smem_pkg.sv | 32 +++
 rtl/smem_responder_if.sv | 23 ++
 rtl/smem_ram.sv | 20 ++
 rtl/smem_responder.sv | 105 ++++++++++
 tb/tb_smem_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/smem_pkg.sv
// Shared types and helpers for the shared-memory responder and its RAM.
// Lane count comes from the N_CORES macro shared with the core array (default 8).
`ifndef N_CORES
`define N_CORES 8
`endif

package smem_pkg;

   localparam int N_CORES = `N_CORES;
   localparam int DATA_W  = 16;
   localparam int LANE_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      DRAIN,
      DONE
   } state_t;

   typedef logic [N_CORES-1:0] lane_mask_t;

   // Index of the lowest set bit; returns 0 for an empty mask.
   function automatic logic [LANE_W-1:0] lowestSetBit(input lane_mask_t mask);
      logic [LANE_W-1:0] idx;
      idx = '0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         if (mask[i]) idx = LANE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/smem_responder_if.sv
// Per-lane load/store bus between the SM controller/core array and the responder.
interface smem_responder_if;
   import smem_pkg::*;

   logic                             MRead;
   logic                             MWrite;
   logic                             MReady;
   logic [N_CORES-1:0]               en;
   logic [N_CORES-1:0][DATA_W-1:0]   addr;
   logic [N_CORES-1:0][DATA_W-1:0]   data;
   logic [N_CORES-1:0][DATA_W-1:0]   q;

   modport master (
      output MRead, MWrite, en, addr, data,
      input  MReady, q
   );

   modport slave (
      input  MRead, MWrite, en, addr, data,
      output MReady, q
   );

endinterface

// File: rtl/smem_ram.sv
// Single-port synchronous RAM, one-cycle read latency, contents never reset.
module smem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/smem_responder.sv
// Serializes enabled lanes of a broadcast load/store onto one single-port RAM.
// Define SMEM_COALESCE_EN to service all pending read lanes sharing an address in one cycle.
module smem_responder
   import smem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   smem_responder_if.slave   bus
);

   state_t                          r_state;
   state_t                          w_next;
   lane_mask_t                      r_pending;
   lane_mask_t                      r_capMask;
   lane_mask_t                      w_sel;
   logic                            r_isRead;
   logic                            r_ready;
   logic [N_CORES-1:0][DATA_W-1:0]  r_q;

   logic [LANE_W-1:0]               w_laneIdx;
   logic [ADDR_W-1:0]               w_ramAddr;
   logic [DATA_W-1:0]               w_ramWdata;
   logic [DATA_W-1:0]               w_ramRdata;
   logic                            w_ramWe;
   logic                            w_req;
   logic                            w_lastGroup;

   assign w_req       = bus.MRead | bus.MWrite;
   assign w_laneIdx   = lowestSetBit(r_pending);
   assign w_ramAddr   = bus.addr[w_laneIdx][ADDR_W-1:0];
   assign w_ramWdata  = bus.data[w_laneIdx];
   // Gating with reset keeps an aborting write from landing one more lane.
   assign w_ramWe     = (r_state == SERVE) && !r_isRead && (r_pending != '0) && !reset;
   assign w_lastGroup = ((r_pending & ~w_sel) == '0);

   // Lanes retired by this SERVE cycle: the lowest pending lane, plus its address twins on reads when coalescing.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N_CORES; i++) begin
`ifdef SMEM_COALESCE_EN
         w_sel[i] = r_pending[i] &&
                    (r_isRead ? (bus.addr[i][ADDR_W-1:0] == w_ramAddr)
                              : (LANE_W'(i) == w_laneIdx));
`else
         w_sel[i] = r_pending[i] && (LANE_W'(i) == w_laneIdx);
`endif
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (w_req) w_next = SERVE;
         SERVE: begin
            if (r_pending == '0)  w_next = DONE;
            else if (w_lastGroup) w_next = r_isRead ? DRAIN : DONE;
         end
         DRAIN: w_next = DONE;
         DONE:  if (!w_req) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_capMask <= '0;
         r_isRead  <= 1'b0;
         r_ready   <= 1'b0;
         r_q       <= '0;
      end else begin
         r_state   <= w_next;
         r_ready   <= (w_next == DONE);
         r_capMask <= ((r_state == SERVE) && r_isRead) ? w_sel : '0;
         if (r_state == IDLE && w_req) begin
            r_pending <= bus.en;
            r_isRead  <= bus.MRead;
         end else if (r_state == SERVE) begin
            r_pending <= r_pending & ~w_sel;
         end
         // RAM data for lanes serviced last cycle arrives now.
         for (int i = 0; i < N_CORES; i++) begin
            if (r_capMask[i]) r_q[i] <= w_ramRdata;
         end
      end
   end

   smem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ramWe),
      .i_addr  (w_ramAddr),
      .i_wdata (w_ramWdata),
      .o_rdata (w_ramRdata)
   );

   assign bus.MReady = r_ready;
   assign bus.q      = r_q;

endmodule

// File: tb/tb_smem_responder.sv
// Self-checking bench for smem_responder: vector table, random ops against a memory model, mid-op reset.
`timescale 1ns/1ps
module tb_smem_responder;
   import smem_pkg::*;

   typedef logic [7:0][15:0] laneVec_t;

   typedef struct {
      string    name;
      logic     rd;
      logic     wr;
      logic [7:0] en;
      laneVec_t addr;
      laneVec_t data;
      int       expLat;
   } vec_t;

   logic clk;
   logic reset;

   smem_responder_if bus();

   smem_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] memModel [256];
   laneVec_t    qModel;
   int          testsRun;
   int          testsFailed;
   vec_t        vecs [13];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic laneVec_t seqVec(input logic [15:0] base);
      laneVec_t v;
      for (int i = 0; i < 8; i++) v[i] = base + 16'(i);
      return v;
   endfunction

   function automatic laneVec_t fillVec(input logic [15:0] val);
      laneVec_t v;
      for (int i = 0; i < 8; i++) v[i] = val;
      return v;
   endfunction

   function automatic int uniqueAddrs(input logic [7:0] en, input laneVec_t addr);
      int u;
      bit seen;
      u = 0;
      for (int i = 0; i < 8; i++) begin
         if (en[i]) begin
            seen = 0;
            for (int j = 0; j < i; j++)
               if (en[j] && addr[j][7:0] == addr[i][7:0]) seen = 1;
            if (!seen) u++;
         end
      end
      return u;
   endfunction

   // Cycles from the request being presented to MReady, straight from the latency rules.
   function automatic int modelLatency(input logic rd, input logic [7:0] en, input laneVec_t addr);
      int k;
      k = $countones(en);
      if (k == 0) return 2;
      if (!rd) return k + 1;
`ifdef SMEM_COALESCE_EN
      return uniqueAddrs(en, addr) + 2;
`else
      return k + 2;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                input logic [7:0] en, input laneVec_t addr,
                                input laneVec_t data, input int expLat);
      int lat;
      lat = -1;
      @(posedge clk);
      #1;
      bus.MRead  = rd;
      bus.MWrite = wr;
      bus.en     = en;
      bus.addr   = addr;
      bus.data   = data;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.MReady === 1'b1) begin
            lat = c;
            break;
         end
      end
      if (rd) begin
         for (int i = 0; i < 8; i++)
            if (en[i]) qModel[i] = memModel[addr[i][7:0]];
      end else begin
         for (int i = 0; i < 8; i++)
            if (en[i]) memModel[addr[i][7:0]] = data[i];
      end
      checkOutput({name, ".latency"}, 128'(lat), 128'(expLat));
      checkOutput({name, ".q"}, bus.q, qModel);
      @(posedge clk);
      #1;
      bus.MRead  = 1'b0;
      bus.MWrite = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, ".readyDrop"}, 128'(bus.MReady), 128'(0));
   endtask

   initial begin
      laneVec_t coalAddr;
      laneVec_t pairAddr;
      laneVec_t pairData;
      laneVec_t rAddr;
      laneVec_t rData;
      logic [7:0] rEn;
      int mode;

      testsRun    = 0;
      testsFailed = 0;
      qModel      = '0;
      bus.MRead   = 1'b0;
      bus.MWrite  = 1'b0;
      bus.en      = '0;
      bus.addr    = '0;
      bus.data    = '0;

      coalAddr = {16'd5, 16'd5, 16'd5, 16'd5, 16'd9, 16'd9, 16'd9, 16'd9};
      pairAddr = seqVec(16'h0000);
      pairAddr[0] = 16'd5;
      pairAddr[1] = 16'd9;
      pairData = fillVec(16'h0000);
      pairData[0] = 16'hAAAA;
      pairData[1] = 16'hBBBB;

      vecs[0]  = '{"wrAll",       1'b0, 1'b1, 8'hFF, seqVec(16'h0000), seqVec(16'h1000), 9};
      vecs[1]  = '{"rdAll",       1'b1, 1'b0, 8'hFF, seqVec(16'h0000), fillVec(16'h0),   10};
      vecs[2]  = '{"wrHigh",      1'b0, 1'b1, 8'hFF, seqVec(16'h0008), seqVec(16'h3000), 9};
      vecs[3]  = '{"wrAgain",     1'b0, 1'b1, 8'hFF, seqVec(16'h0000), seqVec(16'h2000), 9};
      vecs[4]  = '{"rdSparse",    1'b1, 1'b0, 8'hA1, seqVec(16'h0000), fillVec(16'h0),   5};
      vecs[5]  = '{"wrEmpty",     1'b0, 1'b1, 8'h00, seqVec(16'h0000), fillVec(16'hFFFF), 2};
      vecs[6]  = '{"rdAfterEmpty",1'b1, 1'b0, 8'hFF, seqVec(16'h0000), fillVec(16'h0),   10};
      vecs[7]  = '{"wrCollide",   1'b0, 1'b1, 8'hFF, fillVec(16'h0040), seqVec(16'h0000), 9};
      vecs[8]  = '{"rdCollide",   1'b1, 1'b0, 8'h01, fillVec(16'h0040), fillVec(16'h0),   3};
      vecs[9]  = '{"rdWrBoth",    1'b1, 1'b1, 8'hFF, seqVec(16'h0000), fillVec(16'hDEAD), 10};
      vecs[10] = '{"rdUpperBits", 1'b1, 1'b0, 8'hFF, seqVec(16'hAB00), fillVec(16'h0),   10};
      vecs[11] = '{"wrPair",      1'b0, 1'b1, 8'h03, pairAddr, pairData, 3};
`ifdef SMEM_COALESCE_EN
      vecs[12] = '{"rdCoalesce",  1'b1, 1'b0, 8'hFF, coalAddr, fillVec(16'h0),   4};
`else
      vecs[12] = '{"rdCoalesce",  1'b1, 1'b0, 8'hFF, coalAddr, fillVec(16'h0),   10};
`endif

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset.ready", 128'(bus.MReady), 128'(0));
      checkOutput("reset.q", bus.q, 128'(0));

      for (int v = 0; v < 13; v++)
         applyStimulus(vecs[v].name, vecs[v].rd, vecs[v].wr, vecs[v].en,
                       vecs[v].addr, vecs[v].data, vecs[v].expLat);

      // Random ops confined to addresses 0..15, all of which now hold known values.
      for (int n = 0; n < 24; n++) begin
         mode = int'($urandom_range(0, 2));
         rEn  = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            rAddr[i] = {8'($urandom), 8'($urandom_range(0, 15))};
            rData[i] = 16'($urandom);
         end
         applyStimulus($sformatf("rand%0d", n), mode != 0, mode != 1, rEn, rAddr, rData,
                       modelLatency(mode != 0, rEn, rAddr));
      end

      // Abort a full write after two lanes have been serviced.
      applyStimulus("wrBase", 1'b0, 1'b1, 8'hFF, seqVec(16'h0020), seqVec(16'h4000), 9);
      @(posedge clk);
      #1;
      bus.MWrite = 1'b1;
      bus.en     = 8'hFF;
      bus.addr   = seqVec(16'h0020);
      bus.data   = seqVec(16'h5000);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort.ready", 128'(bus.MReady), 128'(0));
      checkOutput("abort.q", bus.q, 128'(0));
      #1;
      reset      = 1'b0;
      bus.MWrite = 1'b0;
      memModel[8'h20] = 16'h5000;
      memModel[8'h21] = 16'h5001;
      qModel = '0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort.idleReady", 128'(bus.MReady), 128'(0));
      applyStimulus("abort.readback", 1'b1, 1'b0, 8'hFF, seqVec(16'h0020), fillVec(16'h0), 10);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
